uart_tx_arbiter: RTL

- Shares the single UART transmitter (tx_data/tx_start/tx_busy interface) between NUM_REQ byte requesters.
- Round-robin arbitration with packet locking, so a multi-byte message from one requester is never interleaved with bytes from another.
- Sequences each byte into the transmitter: issues tx_start, confirms tx_busy rises, then waits for it to fall.
- Sits between CPU-side sources (debug print, monitor responses) and the uart instance.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Holds the FSM state encoding, byte width and id-width helper.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // Index width for n requesters, never below one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first request after the last grant,
// wrapping modulo N. Reusable for any shared-resource arbiter.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        // k=N lands back on i_last itself, so it has lowest priority.
        for (int k = 1; k <= N; k++) begin
            if (!o_any && i_req[(int'(i_last) + k) % N]) begin
                o_any = 1'b1;
                o_gnt[(int'(i_last) + k) % N] = 1'b1;
                o_idx = IW'((int'(i_last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources using
// round-robin arbitration with packet locking and timeout recovery.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  MAX_BURST    = 16,
    parameter int  LOCK_TIMEOUT = 1024,
    parameter int  BUSY_TIMEOUT = 4,
    localparam int IDW          = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         uart_tx_data,
    output logic                      uart_tx_start,
    input  logic                      uart_tx_busy,
    output logic [IDW-1:0]            grant_id,
    output logic                      locked,
    output logic                      byte_done,
    output logic                      err_timeout
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_tx_start;
    logic                r_locked;
    logic                r_byte_done;
    logic                r_err;
    logic [IDW-1:0]      r_grant;
    logic [7:0]          r_burst;
    logic [15:0]         r_idle;
    logic [3:0]          r_wait;

    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [NUM_REQ-1:0]  w_cand;
    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDW-1:0]      w_idx;
    logic                w_any;
    logic                w_accept;
    logic                w_done;
    logic                w_busy_to;
    logic                w_burst_end;
    logic                w_lock_idle;
    logic                w_lock_to;
    logic [BYTE_W-1:0]   w_sel_data;
    logic                w_sel_last;

    // While locked only the owner is a candidate; the picker wraps to it.
    assign w_owner_oh = NUM_REQ'(1) << r_grant;
    assign w_cand     = r_locked ? (req_valid & w_owner_oh) : req_valid;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .i_req  (w_cand),
        .i_last (r_grant),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_sel_data  = req_data[int'(w_idx)*BYTE_W +: BYTE_W];
    assign w_sel_last  = req_last[w_idx];
    assign w_accept    = (r_state == S_IDLE) && !uart_tx_busy && w_any;
    assign req_ready   = w_accept ? w_gnt : '0;
    assign w_done      = (r_state == S_WAIT_DONE) && !uart_tx_busy;
    assign w_busy_to   = (r_state == S_WAIT_BUSY) && !uart_tx_busy
                      && ({1'b0, r_wait} + 5'd1 == 5'(BUSY_TIMEOUT));
    assign w_burst_end = w_sel_last
                      || ({1'b0, r_burst} + 9'd1 == 9'(MAX_BURST));
    assign w_lock_idle = r_locked && (r_state == S_IDLE)
                      && !req_valid[r_grant];
    assign w_lock_to   = w_lock_idle
                      && ({1'b0, r_idle} + 17'd1 == 17'(LOCK_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_START;
            end
            S_START: begin
                w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy)   w_state_nxt = S_WAIT_DONE;
                else if (w_busy_to) w_state_nxt = S_IDLE;
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_locked    <= 1'b0;
            r_byte_done <= 1'b0;
            r_err       <= 1'b0;
            r_grant     <= IDW'(NUM_REQ - 1);
            r_burst     <= '0;
            r_idle      <= '0;
            r_wait      <= '0;
        end else begin
            r_tx_start  <= w_accept;
            r_byte_done <= w_done;
            r_err       <= w_busy_to || w_lock_to;

            if (w_accept) begin
                r_tx_data <= w_sel_data;
                r_grant   <= w_idx;
                r_idle    <= '0;
                if (w_burst_end) begin
                    r_locked <= 1'b0;
                    r_burst  <= '0;
                end else begin
                    r_locked <= 1'b1;
                    r_burst  <= r_burst + 8'd1;
                end
            end else if (w_lock_to) begin
                r_locked <= 1'b0;
                r_burst  <= '0;
                r_idle   <= '0;
            end else if (w_lock_idle) begin
                r_idle <= r_idle + 16'd1;
            end else if (!r_locked) begin
                r_idle <= '0;
            end

            // A dropped byte also abandons the packet it belonged to.
            if (w_busy_to) begin
                r_locked <= 1'b0;
                r_burst  <= '0;
            end

            if (r_state == S_START) r_wait <= '0;
            else if (r_state == S_WAIT_BUSY && !uart_tx_busy)
                r_wait <= r_wait + 4'd1;
        end
    end

    assign uart_tx_data  = r_tx_data;
    assign uart_tx_start = r_tx_start;
    assign grant_id      = r_grant;
    assign locked        = r_locked;
    assign byte_done     = r_byte_done;
    assign err_timeout   = r_err;

endmodule
